rv32_wb_arbiter: RTL and testbench

Shares the register file's single write port between the in-order pipeline writeback and a long-latency execution unit (divider/multiplier) that returns results out of band. It buffers long-latency results in a small FIFO and keeps a 32-entry pending-destination scoreboard. It stalls decode on RAW/WAW hazards against outstanding long-latency results. It sits between writeback, the long-latency unit and `rv32_regs`, and drives the regfile's `rd_in`, `rd_write_in` and `rd_value_in`.

---
 rtl/rv32_wb_arbiter.sv | 140 ++++++++++++++
 tb/tb_rv32_wb_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. buffered long-latency results, with a
// pending-destination scoreboard for hazard stalls. Optional starvation guard: RV32_WB_STARVE_GUARD_EN.
module rv32_wb_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  pipe_rd_in,
  input  logic        pipe_rd_write_in,
  input  logic        pipe_flush_in,
  input  logic [31:0] pipe_rd_value_in,
  input  logic        mc_valid_in,
  output logic        mc_ready_out,
  input  logic [4:0]  mc_rd_in,
  input  logic [31:0] mc_value_in,
  input  logic        issue_mc_in,
  input  logic [4:0]  issue_rd_in,
  input  logic [4:0]  dec_rs1_in,
  input  logic [4:0]  dec_rs2_in,
  input  logic [4:0]  dec_rd_in,
  output logic        stall_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] value;
  } mc_entry_t;

  mc_entry_t      mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic [31:0]    pending_q, pending_d;
  logic [4:0]     rd_q, rd_d;
  logic           rd_write_q, rd_write_d;
  logic [31:0]    rd_value_q, rd_value_d;

  logic           full, empty, push, pop, pw;
  logic           sel_pipe, sel_fifo, forced_drain, hazard;
  mc_entry_t      head;

  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);
  assign mc_ready_out = ~full;
  assign push         = mc_valid_in & ~full;
  assign head         = mem_q[rd_ptr_q];
  assign pw           = pipe_rd_write_in & ~pipe_flush_in & (|pipe_rd_in);

`ifdef RV32_WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_q;

  assign forced_drain = ~empty & (starve_q >= SW'(STARVE_LIMIT));

  // Counts cycles a buffered result loses to the pipeline; any pop restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  starve_q <= '0;
    else if (pop)               starve_q <= '0;
    else if (~empty & sel_pipe) starve_q <= starve_q + SW'(1);
  end
`else
  assign forced_drain = 1'b0;
`endif

  assign sel_fifo = ~empty & (forced_drain | ~pw);
  assign sel_pipe = pw & ~forced_drain;
  assign pop      = sel_fifo;

  assign hazard = (pending_q[dec_rs1_in] & (|dec_rs1_in)) |
                  (pending_q[dec_rs2_in] & (|dec_rs2_in)) |
                  (pending_q[dec_rd_in]  & (|dec_rd_in));
  assign stall_out = hazard | forced_drain;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_d       = '0;
    rd_write_d = 1'b0;
    rd_value_d = '0;
    pending_d  = pending_q;
    count_d    = count_q;

    if (sel_pipe) begin
      rd_d       = pipe_rd_in;
      rd_write_d = 1'b1;
      rd_value_d = pipe_rd_value_in;
    end else if (sel_fifo) begin
      rd_d       = head.rd;
      rd_write_d = |head.rd;
      rd_value_d = head.value;
    end

    // Clear before set so an issue to the same register in the drain cycle keeps it pending.
    if (sel_fifo) pending_d[head.rd] = 1'b0;
    if (issue_mc_in & ~stall_out & (|issue_rd_in)) pending_d[issue_rd_in] = 1'b1;
    pending_d[0] = 1'b0;

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pending_q  <= '0;
      rd_q       <= '0;
      rd_write_q <= 1'b0;
      rd_value_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q    <= count_d;
      pending_q  <= pending_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      rd_value_q <= rd_value_d;
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the count guarantees stale slots are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{rd: mc_rd_in, value: mc_value_in};
  end

  assign rd_out       = rd_q;
  assign rd_write_out = rd_write_q;
  assign rd_value_out = rd_value_q;

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed self-checking bench for rv32_wb_arbiter (DEPTH=2, STARVE_LIMIT=4); expectations follow
// RV32_WB_STARVE_GUARD_EN when it is defined.
module tb_rv32_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  pipe_rd_in;
  logic        pipe_rd_write_in;
  logic        pipe_flush_in;
  logic [31:0] pipe_rd_value_in;
  logic        mc_valid_in;
  logic        mc_ready_out;
  logic [4:0]  mc_rd_in;
  logic [31:0] mc_value_in;
  logic        issue_mc_in;
  logic [4:0]  issue_rd_in;
  logic [4:0]  dec_rs1_in, dec_rs2_in, dec_rd_in;
  logic        stall_out;
  logic [4:0]  rd_out;
  logic        rd_write_out;
  logic [31:0] rd_value_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  rv32_wb_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .pipe_rd_in       (pipe_rd_in),
    .pipe_rd_write_in (pipe_rd_write_in),
    .pipe_flush_in    (pipe_flush_in),
    .pipe_rd_value_in (pipe_rd_value_in),
    .mc_valid_in      (mc_valid_in),
    .mc_ready_out     (mc_ready_out),
    .mc_rd_in         (mc_rd_in),
    .mc_value_in      (mc_value_in),
    .issue_mc_in      (issue_mc_in),
    .issue_rd_in      (issue_rd_in),
    .dec_rs1_in       (dec_rs1_in),
    .dec_rs2_in       (dec_rs2_in),
    .dec_rd_in        (dec_rd_in),
    .stall_out        (stall_out),
    .rd_out           (rd_out),
    .rd_write_out     (rd_write_out),
    .rd_value_out     (rd_value_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_rd_in = '0; pipe_rd_write_in = 1'b0; pipe_flush_in = 1'b0; pipe_rd_value_in = '0;
    mc_valid_in = 1'b0; mc_rd_in = '0; mc_value_in = '0;
    issue_mc_in = 1'b0; issue_rd_in = '0;
    dec_rs1_in = '0; dec_rs2_in = '0; dec_rd_in = '0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_mc_in = 1'b1; issue_rd_in = rd;
    tick();
    issue_mc_in = 1'b0; issue_rd_in = '0;
  endtask

  task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] val);
    check({tag, " wr"},  {31'd0, rd_write_out}, 32'd1);
    check({tag, " rd"},  {27'd0, rd_out}, {27'd0, rd});
    check({tag, " val"}, rd_value_out, val);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    reset = 1'b1;
    repeat (2) tick();
    check("rst rd_out",   {27'd0, rd_out}, 32'd0);
    check("rst rd_write", {31'd0, rd_write_out}, 32'd0);
    check("rst rd_value", rd_value_out, 32'd0);
    check("rst ready",    {31'd0, mc_ready_out}, 32'd1);
    check("rst stall",    {31'd0, stall_out}, 32'd0);
    reset = 1'b0;
    tick();

    // RAW stall on x5 until the divider result drains
    issue(5'd5);
    dec_rs1_in = 5'd5; #1;
    check("A stall set", {31'd0, stall_out}, 32'd1);
    tick(); tick();
    check("A stall hold", {31'd0, stall_out}, 32'd1);
    check("A no write",   {31'd0, rd_write_out}, 32'd0);
    mc_valid_in = 1'b1; mc_rd_in = 5'd5; mc_value_in = 32'h2A; #1;
    check("A ready", {31'd0, mc_ready_out}, 32'd1);
    tick();
    mc_valid_in = 1'b0; #1;
    check("A stall pop cyc", {31'd0, stall_out}, 32'd1);
    tick();
    check_write("A drain", 5'd5, 32'h2A);
    check("A unstall", {31'd0, stall_out}, 32'd0);
    dec_rs1_in = '0;
    tick();
    check("A idle", {31'd0, rd_write_out}, 32'd0);

    // Pipeline and long-latency result arrive together: pipeline first
    issue(5'd7);
    pipe_rd_write_in = 1'b1; pipe_rd_in = 5'd3; pipe_rd_value_in = 32'h11;
    mc_valid_in = 1'b1; mc_rd_in = 5'd7; mc_value_in = 32'h22;
    dec_rs2_in = 5'd7;
    tick();
    pipe_rd_write_in = 1'b0; mc_valid_in = 1'b0; #1;
    check_write("B pipe", 5'd3, 32'h11);
    check("B stall", {31'd0, stall_out}, 32'd1);
    tick();
    check_write("B mc", 5'd7, 32'h22);
    check("B unstall", {31'd0, stall_out}, 32'd0);
    dec_rs2_in = '0;

    // Fill FIFO under continuous pipeline writes
    issue(5'd10);
    issue(5'd11);
    pipe_rd_write_in = 1'b1; pipe_rd_in = 5'd1; pipe_rd_value_in = 32'h100;
    mc_valid_in = 1'b1; mc_rd_in = 5'd10; mc_value_in = 32'hA0; #1;
    check("C ready empty", {31'd0, mc_ready_out}, 32'd1);
    tick();
    mc_rd_in = 5'd11; mc_value_in = 32'hB0; #1;
    check("C ready one", {31'd0, mc_ready_out}, 32'd1);
    tick();
    mc_valid_in = 1'b0; #1;
    check("C full", {31'd0, mc_ready_out}, 32'd0);
    check_write("C pipe0", 5'd1, 32'h100);
    for (int i = 0; i < 4; i++) begin
`ifdef RV32_WB_STARVE_GUARD_EN
      check("C stall", {31'd0, stall_out}, (i == 3) ? 32'd1 : 32'd0);
      tick();
      if (i == 3) check_write("C forced", 5'd10, 32'hA0);
      else        check_write("C pipe", 5'd1, 32'h100);
`else
      check("C stall", {31'd0, stall_out}, 32'd0);
      tick();
      check_write("C pipe", 5'd1, 32'h100);
`endif
    end
    pipe_rd_write_in = 1'b0;
`ifndef RV32_WB_STARVE_GUARD_EN
    tick();
    check_write("C drain10", 5'd10, 32'hA0);
`endif
    tick();
    check_write("C drain11", 5'd11, 32'hB0);
    tick();
    check("C idle", {31'd0, rd_write_out}, 32'd0);
    check("C ready again", {31'd0, mc_ready_out}, 32'd1);

    // Zero destination and flush let the FIFO drain
    issue(5'd12);
    pipe_rd_write_in = 1'b1; pipe_rd_in = 5'd3; pipe_rd_value_in = 32'h33;
    mc_valid_in = 1'b1; mc_rd_in = 5'd12; mc_value_in = 32'h55;
    tick();
    mc_valid_in = 1'b0;
    check_write("D pipe", 5'd3, 32'h33);
    pipe_rd_in = 5'd0;
    tick();
    check_write("D rd0 drain", 5'd12, 32'h55);
    issue(5'd13);
    pipe_rd_in = 5'd4; pipe_rd_value_in = 32'h44;
    mc_valid_in = 1'b1; mc_rd_in = 5'd13; mc_value_in = 32'h66;
    tick();
    mc_valid_in = 1'b0;
    check_write("D pipe4", 5'd4, 32'h44);
    pipe_flush_in = 1'b1;
    tick();
    check_write("D flush drain", 5'd13, 32'h66);
    pipe_flush_in = 1'b0; pipe_rd_write_in = 1'b0;
    tick();
    check("D idle", {31'd0, rd_write_out}, 32'd0);

    // Reset with two buffered results and pending = 0x880
    issue(5'd7);
    issue(5'd11);
    pipe_rd_write_in = 1'b1; pipe_rd_in = 5'd1; pipe_rd_value_in = 32'h1;
    mc_valid_in = 1'b1; mc_rd_in = 5'd7; mc_value_in = 32'h70;
    tick();
    mc_rd_in = 5'd11; mc_value_in = 32'hB1;
    tick();
    mc_valid_in = 1'b0; dec_rs1_in = 5'd7; #1;
    check("E full", {31'd0, mc_ready_out}, 32'd0);
    check("E stall", {31'd0, stall_out}, 32'd1);
    reset = 1'b1; pipe_rd_write_in = 1'b0; #1;
    check("E rst rd",    {27'd0, rd_out}, 32'd0);
    check("E rst wr",    {31'd0, rd_write_out}, 32'd0);
    check("E rst val",   rd_value_out, 32'd0);
    check("E rst ready", {31'd0, mc_ready_out}, 32'd1);
    check("E rst stall7", {31'd0, stall_out}, 32'd0);
    dec_rs1_in = '0; dec_rs2_in = 5'd11; #1;
    check("E rst stall11", {31'd0, stall_out}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("E no write", {31'd0, rd_write_out}, 32'd0);
    end
    dec_rs2_in = '0;

    // WAW stall, stalled issue ignored, x0 never pending
    issue(5'd0);
    #1;
    check("F x0 issue", {31'd0, stall_out}, 32'd0);
    issue(5'd9);
    dec_rd_in = 5'd9; #1;
    check("F waw", {31'd0, stall_out}, 32'd1);
    issue(5'd20);
    dec_rd_in = '0; dec_rs1_in = 5'd20; #1;
    check("F stalled issue", {31'd0, stall_out}, 32'd0);
    dec_rs1_in = '0; dec_rd_in = 5'd9;
    mc_valid_in = 1'b1; mc_rd_in = 5'd9; mc_value_in = 32'h99;
    tick();
    mc_valid_in = 1'b0; #1;
    check("F waw hold", {31'd0, stall_out}, 32'd1);
    tick();
    check_write("F drain", 5'd9, 32'h99);
    check("F unstall", {31'd0, stall_out}, 32'd0);
    dec_rd_in = '0;
    mc_valid_in = 1'b1; mc_rd_in = 5'd0; mc_value_in = 32'h77;
    tick();
    mc_valid_in = 1'b0;
    tick();
    check("F x0 entry", {31'd0, rd_write_out}, 32'd0);
    tick();
    check("F end ready", {31'd0, mc_ready_out}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
